hilo_mult_unit: RTL and testbench
=================================

# hilo_mult_unit

Multi-cycle signed multiplier that executes the `EXE_MULT`, `EXE_MFHI` and `EXE_MFLO` commands issued by the controller. It owns the architectural HI/LO register pair. It sits in the EXE stage beside the ALU and drives a stall request back to the hazard logic while a multiply is in flight. The controller produces these commands; this block is the execution-side consumer of them.

## Interface
- `WORD_LEN`, 32, operand/result width (from `defines.v`)
- `EXE_CMD_LEN`, from `defines.v`, width of the execute command
- `clk`  input  1  rising-edge clock
- `rst`  input  1  asynchronous, active-low reset
- `cmd_valid`  input  1  EXE stage holds a live instruction (not a bubble)
- `EXE_CMD`  input  EXE_CMD_LEN  command from ID/EX register
- `val1`  input  WORD_LEN  rs operand (multiplicand)
- `val2`  input  WORD_LEN  rt operand (multiplier)
- `flush`  input  1  pipeline flush; kills an in-flight multiply
- `stall`  output  1  request to freeze IF/ID/EX
- `mf_result`  output  WORD_LEN  HI or LO value for MFHI/MFLO
- `done`  output  1  one-cycle pulse; HI/LO just updated
- `HI`, `LO`  output  WORD_LEN each  architectural registers

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - `cmd_valid && EXE_CMD==EXE_MULT && !flush` → latch |val1| into mcand, |val2| into mplier, sign = val1[31]^val2[31], acc=0, cnt=0 → RUN.
  - Any other command leaves the state in IDLE.
- RUN, one iteration per cycle:
  - If mplier[0], add mcand into acc[63:32].
  - Shift {acc, mplier} right by 1; the adder carry feeds acc[63].
  - cnt++. When cnt==31 at the edge → DONE.
- DONE: product = sign ? −acc : acc (64-bit two's complement). At the edge, {HI,LO} ← product, `done` ← 1, state → IDLE.
- Width rules:
  - 64-bit accumulator with a 33-bit add so the carry is kept.
  - Magnitude of 0x80000000 is 0x80000000 treated as unsigned; this is not an overflow.
- `stall` (combinational) = `cmd_valid && state!=IDLE && EXE_CMD ∈ {EXE_MULT, EXE_MFHI, EXE_MFLO}`, OR (`state==IDLE` && accepting a MULT this cycle).
  - The accepting MULT holds its own slot until DONE.
  - Unrelated ALU instructions are not stalled; they proceed while RUN is active.
- `mf_result` (combinational): HI when EXE_CMD==EXE_MFHI, LO when EXE_CMD==EXE_MFLO, else 0. It is only meaningful when `stall`==0.
- MULT arriving while busy is held by the stall and accepted on the first cycle back in IDLE.
- `flush` in RUN or DONE → IDLE at the next edge. HI/LO stay unchanged and `done` does not pulse.
- `flush` has priority over acceptance and over the DONE write.

## Timing
- Accept at cycle N (IDLE, MULT valid):
  - RUN occupies cycles N+1..N+32.
  - DONE is cycle N+33.
  - New HI/LO and `done`=1 are visible in cycle N+34.
- `stall` is high in cycles N..N+33 while the MULT or a dependent MF* is in EX. It is low in N+34, when MFHI/MFLO reads the new value the same cycle.
- Back-to-back MULT: the second is accepted at N+34 at the earliest.
- Reset values (async, `rst`=0): state=IDLE; HI=LO=0; acc, mcand, mplier, cnt, sign = 0; `done`=0; `stall`=0; `mf_result`=0 (combinational from cmd).
- Reset asserted mid-RUN aborts immediately. No write occurs and HI/LO read 0.

## Structure
- Add to `defines.v`:
  - `MULT_ST_IDLE`, `MULT_ST_RUN`, `MULT_ST_DONE` state encodings.
  - `MULT_ITER` (=32).
  - `EXE_MULT`, `EXE_MFHI` and `EXE_MFLO` already live there and are reused unchanged.
- Sub-module `shift_add_step`: combinational single iteration, taking {acc, mplier, mcand} to the next {acc, mplier}. It keeps the FSM file small and lets the step be unit-tested.
- HI/LO move out of the controller into this block. The controller no longer declares them.

## Test plan
- MULT 3 × 5 at N → `stall` high N..N+33; at N+34 HI=0x00000000, LO=0x0000000F, `done`=1 for exactly one cycle.
- MULT 0xFFFFFFFE × 3 (−2×3) → HI=0xFFFFFFFF, LO=0xFFFFFFFA at N+34.
- MULT 0x80000000 × 0x80000000 → HI=0x40000000, LO=0x00000000; 0x7FFFFFFF × 0x7FFFFFFF → HI=0x3FFFFFFF, LO=0x00000001.
- MULT 7 × 6, then MFLO presented at N+1 → `stall` held until N+33; at N+34 `stall`=0 and `mf_result`=0x0000002A. An ADD presented at N+5 is not stalled.
- HI/LO preloaded to 0x11/0x22; MULT 9 × 9 with `flush` at N+10 → IDLE at N+11; HI=0x11, LO=0x22; `done` never pulses; `stall`=0.
- `rst` low at N+20 of a MULT → immediately IDLE, HI=LO=0, `done`=0. After release, MULT 2 × 2 completes 34 cycles after acceptance with LO=4.

Source files
------------

// File: rtl/hilo_mult_unit_pkg.sv
// Shared constants and types for the HI/LO multiply unit.
// Command codes match the rest of the EXE stage.
package hilo_mult_unit_pkg;

  localparam int WORD_LEN    = 32;
  localparam int EXE_CMD_LEN = 4;
  localparam int MULT_ITER   = 32;

  localparam logic [EXE_CMD_LEN-1:0] EXE_ADD  = 4'b0000;
  localparam logic [EXE_CMD_LEN-1:0] EXE_MULT = 4'b1010;
  localparam logic [EXE_CMD_LEN-1:0] EXE_MFHI = 4'b1011;
  localparam logic [EXE_CMD_LEN-1:0] EXE_MFLO = 4'b1100;

  localparam logic [1:0] MULT_ST_IDLE = 2'd0;
  localparam logic [1:0] MULT_ST_RUN  = 2'd1;
  localparam logic [1:0] MULT_ST_DONE = 2'd2;

  typedef logic [WORD_LEN-1:0]   word_t;
  typedef logic [2*WORD_LEN-1:0] dword_t;

  // 0x80000000 maps to itself, read as unsigned
  function automatic word_t abs_word(input word_t x);
    return x[WORD_LEN-1] ? word_t'(-x) : x;
  endfunction

endpackage

// File: rtl/hilo_mult_unit_step.sv
// One shift-add iteration of the unsigned magnitude multiply.
// The 33-bit sum keeps the carry, which becomes acc[63].
module shift_add_step
  import hilo_mult_unit_pkg::*;
(
  input  logic [2*WORD_LEN-1:0] acc_in,
  input  logic [WORD_LEN-1:0]   mplier_in,
  input  logic [WORD_LEN-1:0]   mcand,
  output logic [2*WORD_LEN-1:0] acc_out,
  output logic [WORD_LEN-1:0]   mplier_out
);

  logic [WORD_LEN:0]     sum;
  logic [3*WORD_LEN:0]   cat;

  always_comb begin
    sum = {1'b0, acc_in[2*WORD_LEN-1:WORD_LEN]};
    if (mplier_in[0])
      sum = sum + {1'b0, mcand};
    cat        = {sum, acc_in[WORD_LEN-1:0], mplier_in};
    acc_out    = cat[3*WORD_LEN:WORD_LEN+1];
    mplier_out = cat[WORD_LEN:1];
  end

endmodule

// File: rtl/hilo_mult_unit.sv
// Multi-cycle signed multiplier owning the HI/LO pair.
// Stalls IF/ID/EX while a MULT or dependent MF* sits in EX.
module hilo_mult_unit
  import hilo_mult_unit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  input  logic [EXE_CMD_LEN-1:0] EXE_CMD,
  input  logic [WORD_LEN-1:0]    val1,
  input  logic [WORD_LEN-1:0]    val2,
  input  logic                   flush,
  output logic                   stall,
  output logic [WORD_LEN-1:0]    mf_result,
  output logic                   done,
  output logic [WORD_LEN-1:0]    HI,
  output logic [WORD_LEN-1:0]    LO
);

  localparam int CNT_W = $clog2(MULT_ITER);

  logic [1:0]            state;
  logic [CNT_W-1:0]      cnt;
  logic [WORD_LEN-1:0]   mcand;
  logic [WORD_LEN-1:0]   mplier;
  logic [2*WORD_LEN-1:0] acc;
  logic                  sign;

  logic [2*WORD_LEN-1:0] acc_nx;
  logic [WORD_LEN-1:0]   mplier_nx;
  logic [2*WORD_LEN-1:0] product;
  logic                  is_mdu;
  logic                  accept;

  shift_add_step u_step (
    .acc_in     (acc),
    .mplier_in  (mplier),
    .mcand      (mcand),
    .acc_out    (acc_nx),
    .mplier_out (mplier_nx)
  );

  assign is_mdu = (EXE_CMD == EXE_MULT) ||
                  (EXE_CMD == EXE_MFHI) ||
                  (EXE_CMD == EXE_MFLO);

  assign accept = (state == MULT_ST_IDLE) && cmd_valid &&
                  (EXE_CMD == EXE_MULT) && !flush;

  assign stall = (cmd_valid && (state != MULT_ST_IDLE) && is_mdu) ||
                 accept;

  assign product = sign ? (2*WORD_LEN)'(-acc) : acc;

  always_comb begin
    mf_result = '0;
    unique case (1'b1)
      (EXE_CMD == EXE_MFHI): mf_result = HI;
      (EXE_CMD == EXE_MFLO): mf_result = LO;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= MULT_ST_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      sign   <= 1'b0;
      HI     <= '0;
      LO     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (flush && (state != MULT_ST_IDLE)) begin
        state <= MULT_ST_IDLE;
      end else begin
        unique case (state)
          MULT_ST_IDLE: begin
            if (accept) begin
              mcand  <= abs_word(val1);
              mplier <= abs_word(val2);
              sign   <= val1[WORD_LEN-1] ^ val2[WORD_LEN-1];
              acc    <= '0;
              cnt    <= '0;
              state  <= MULT_ST_RUN;
            end
          end
          MULT_ST_RUN: begin
            acc    <= acc_nx;
            mplier <= mplier_nx;
            cnt    <= cnt + 1'b1;
            if (cnt == CNT_W'(MULT_ITER-1))
              state <= MULT_ST_DONE;
          end
          MULT_ST_DONE: begin
            HI    <= product[2*WORD_LEN-1:WORD_LEN];
            LO    <= product[WORD_LEN-1:0];
            done  <= 1'b1;
            state <= MULT_ST_IDLE;
          end
          default: state <= MULT_ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hilo_mult_unit.sv
// Directed bench for hilo_mult_unit with a cycle-level
// reference model checked on every negative clock edge.
module tb_hilo_mult_unit;
  import hilo_mult_unit_pkg::*;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cmd_valid;
  logic [EXE_CMD_LEN-1:0] EXE_CMD;
  logic [WORD_LEN-1:0]    val1;
  logic [WORD_LEN-1:0]    val2;
  logic                   flush;
  logic                   stall;
  logic [WORD_LEN-1:0]    mf_result;
  logic                   done;
  logic [WORD_LEN-1:0]    HI;
  logic [WORD_LEN-1:0]    LO;

  int checks = 0;
  int errors = 0;

  hilo_mult_unit dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .EXE_CMD   (EXE_CMD),
    .val1      (val1),
    .val2      (val2),
    .flush     (flush),
    .stall     (stall),
    .mf_result (mf_result),
    .done      (done),
    .HI        (HI),
    .LO        (LO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] prod64(input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] x;
    logic signed [63:0] y;
    x = {{32{a[31]}}, a};
    y = {{32{b[31]}}, b};
    return x * y;
  endfunction

  // Reference: cycles left until the product becomes visible.
  int          m_left;
  logic [63:0] m_prod;
  logic [31:0] m_hi;
  logic [31:0] m_lo;
  logic        m_done;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_left <= 0;
      m_prod <= '0;
      m_hi   <= '0;
      m_lo   <= '0;
      m_done <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        if (flush) begin
          m_left <= 0;
        end else begin
          m_left <= m_left - 1;
          if (m_left == 1) begin
            m_hi   <= m_prod[63:32];
            m_lo   <= m_prod[31:0];
            m_done <= 1'b1;
          end
        end
      end else if (cmd_valid && EXE_CMD == EXE_MULT && !flush) begin
        m_left <= 33;
        m_prod <= prod64(val1, val2);
      end
    end
  end

  always @(negedge clk) begin : compare
    logic        e_stall;
    logic        mdu;
    logic [31:0] e_mf;
    mdu = (EXE_CMD == EXE_MULT) || (EXE_CMD == EXE_MFHI) ||
          (EXE_CMD == EXE_MFLO);
    if (m_left > 0)
      e_stall = cmd_valid && mdu;
    else
      e_stall = cmd_valid && (EXE_CMD == EXE_MULT) && !flush;
    e_mf = (EXE_CMD == EXE_MFHI) ? m_hi :
           (EXE_CMD == EXE_MFLO) ? m_lo : 32'h0;
    chk("model_stall", 32'(stall), 32'(e_stall));
    chk("model_done", 32'(done), 32'(m_done));
    chk("model_hi", HI, m_hi);
    chk("model_lo", LO, m_lo);
    if (!e_stall)
      chk("model_mf", mf_result, e_mf);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mult(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo,
                         input logic [3:0] fill, input int add_at);
    cmd_valid = 1'b1;
    EXE_CMD   = EXE_MULT;
    val1      = a;
    val2      = b;
    @(negedge clk);
    chk("accept_stall", 32'(stall), 32'd1);
    for (int k = 1; k <= 33; k++) begin
      step();
      EXE_CMD = (k == add_at) ? EXE_ADD : fill;
      val1    = '0;
      val2    = '0;
      @(negedge clk);
      if (k == add_at)
        chk("add_not_stalled", 32'(stall), 32'd0);
      if (k == 33) begin
        chk("last_stall", 32'(stall), 32'd1);
        chk("last_no_done", 32'(done), 32'd0);
      end
    end
    step();
    EXE_CMD = EXE_MFLO;
    @(negedge clk);
    chk("result_stall", 32'(stall), 32'd0);
    chk("result_done", 32'(done), 32'd1);
    chk("result_hi", HI, hi);
    chk("result_lo", LO, lo);
    chk("result_mflo", mf_result, lo);
    step();
    cmd_valid = 1'b0;
    EXE_CMD   = EXE_ADD;
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    EXE_CMD   = EXE_ADD;
    val1      = '0;
    val2      = '0;
    flush     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cmd_valid = 1'b1;
    EXE_CMD   = EXE_MFHI;
    @(negedge clk);
    chk("rst_hi", HI, 32'h0);
    chk("rst_lo", LO, 32'h0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_mf", mf_result, 32'h0);
    step();
    cmd_valid = 1'b0;
    rst       = 1'b1;
    step();

    do_mult(32'd3, 32'd5, 32'h0, 32'hF, EXE_MFHI, 0);
    do_mult(32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
            EXE_MFLO, 0);
    do_mult(32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,
            EXE_MFHI, 0);
    do_mult(32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h1,
            EXE_MFHI, 0);
    do_mult(32'd7, 32'd6, 32'h0, 32'h2A, EXE_MFLO, 5);

    // 0x66 * 0x2AAAAAAB = 0x00000011_00000022
    do_mult(32'h66, 32'h2AAA_AAAB, 32'h11, 32'h22, EXE_MFHI, 0);
    cmd_valid = 1'b1;
    EXE_CMD   = EXE_MULT;
    val1      = 32'd9;
    val2      = 32'd9;
    @(negedge clk);
    for (int k = 1; k <= 10; k++) begin
      step();
      EXE_CMD = EXE_MFHI;
      flush   = (k == 10);
      @(negedge clk);
    end
    step();
    flush     = 1'b0;
    cmd_valid = 1'b0;
    EXE_CMD   = EXE_ADD;
    @(negedge clk);
    chk("flush_stall", 32'(stall), 32'd0);
    chk("flush_hi", HI, 32'h11);
    chk("flush_lo", LO, 32'h22);
    chk("flush_done", 32'(done), 32'd0);
    pulses = 0;
    repeat (30) begin
      step();
      @(negedge clk);
      if (done) pulses++;
    end
    chk("flush_no_pulse", 32'(pulses), 32'd0);
    step();

    cmd_valid = 1'b1;
    EXE_CMD   = EXE_MULT;
    val1      = 32'd5;
    val2      = 32'd5;
    @(negedge clk);
    for (int k = 1; k <= 20; k++) begin
      step();
      EXE_CMD = EXE_MFHI;
      if (k == 20) begin
        rst       = 1'b0;
        cmd_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("midrst_hi", HI, 32'h0);
    chk("midrst_lo", LO, 32'h0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_stall", 32'(stall), 32'd0);
    step();
    rst = 1'b1;
    step();
    do_mult(32'd2, 32'd2, 32'h0, 32'h4, EXE_MFLO, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
